reg_writeback_unit: RTL and testbench

//   Write side of the decode-stage register file (regFile). Accepts results from the
//   ALU (one beat, full vector) and from memory loads (one lane per beat). Assembles

---
 rtl/reg_writeback_unit.sv | 126 ++++++++++++
 tb/tb_reg_writeback_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_unit.sv
// Register-file write side: merges one-beat ALU results and lane-by-lane loads into a single write port.
// Latency: ALU accept -> write next cycle; final load beat -> write two cycles later. Both inputs stall only in FULL.
module reg_writeback_unit #(
    parameter int REGISTER_SIZE  = 16,
    parameter int VECTOR_SIZE    = 4,
    parameter int SELECTION_BITS = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   alu_valid,
    output logic                                   alu_ready,
    input  logic [SELECTION_BITS-1:0]              alu_dest,
    input  logic [VECTOR_SIZE*REGISTER_SIZE-1:0]   alu_data,
    input  logic                                   mem_valid,
    output logic                                   mem_ready,
    input  logic [SELECTION_BITS-1:0]              mem_dest,
    input  logic [REGISTER_SIZE-1:0]               mem_lane_data,
    output logic                                   regWrEnSc,
    output logic                                   regWrEnVec,
    output logic [SELECTION_BITS-1:0]              regToWrite,
    output logic [VECTOR_SIZE*REGISTER_SIZE-1:0]   dataIn,
    output logic                                   wb_pending,
    output logic [SELECTION_BITS-1:0]              wb_pending_dest
);
    localparam int DW = VECTOR_SIZE * REGISTER_SIZE;
    localparam int CW = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(VECTOR_SIZE - 1);

    typedef enum logic [1:0] {IDLE, ASSEMBLE, FULL} state_t;

    state_t                    state_q;
    logic [CW-1:0]             lane_cnt_q;
    logic [DW-1:0]             buf_q;
    logic [SELECTION_BITS-1:0] dest_q;

    logic                      wr_sc_q, wr_vec_q, wr_sc_d, wr_vec_d;
    logic [SELECTION_BITS-1:0] wr_dest_q, wr_dest_d;
    logic [DW-1:0]             wr_data_q, wr_data_d;
    logic                      alu_fire, mem_fire;

    assign alu_ready       = (state_q != FULL);
    assign mem_ready       = (state_q != FULL);
    assign wb_pending      = (state_q != IDLE);
    assign wb_pending_dest = dest_q;
    assign alu_fire        = alu_valid && alu_ready;
    assign mem_fire        = mem_valid && mem_ready;

    assign regWrEnSc  = wr_sc_q;
    assign regWrEnVec = wr_vec_q;
    assign regToWrite = wr_dest_q;
    assign dataIn     = wr_data_q;

    // The buffered load owns the port in FULL; ALU is held off by alu_ready that cycle.
    always_comb begin
        wr_sc_d   = 1'b0;
        wr_vec_d  = 1'b0;
        wr_dest_d = wr_dest_q;
        wr_data_d = wr_data_q;
        if (state_q == FULL) begin
            wr_dest_d = dest_q;
            wr_data_d = buf_q;
            wr_sc_d   = dest_q[SELECTION_BITS-2];
            wr_vec_d  = !dest_q[SELECTION_BITS-2];
        end else if (alu_fire) begin
            wr_dest_d = alu_dest;
            wr_sc_d   = alu_dest[SELECTION_BITS-2];
            wr_vec_d  = !alu_dest[SELECTION_BITS-2];
            if (alu_dest[SELECTION_BITS-2])
                wr_data_d = {{(DW-REGISTER_SIZE){1'b0}}, alu_data[REGISTER_SIZE-1:0]};
            else
                wr_data_d = alu_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_sc_q   <= 1'b0;
            wr_vec_q  <= 1'b0;
            wr_dest_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_sc_q   <= wr_sc_d;
            wr_vec_q  <= wr_vec_d;
            wr_dest_q <= wr_dest_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            lane_cnt_q <= '0;
            buf_q      <= '0;
            dest_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_fire) begin
                        dest_q <= mem_dest;
                        // Clearing the upper lanes keeps scalar loads zero-extended.
                        buf_q  <= {{(DW-REGISTER_SIZE){1'b0}}, mem_lane_data};
                        if (mem_dest[SELECTION_BITS-2]) begin
                            state_q <= FULL;
                        end else begin
                            lane_cnt_q <= CW'(1);
                            state_q    <= ASSEMBLE;
                        end
                    end
                end
                ASSEMBLE: begin
                    if (mem_fire) begin
                        buf_q[lane_cnt_q*REGISTER_SIZE +: REGISTER_SIZE] <= mem_lane_data;
                        if (lane_cnt_q == LAST_LANE) begin
                            lane_cnt_q <= '0;
                            state_q    <= FULL;
                        end else begin
                            lane_cnt_q <= lane_cnt_q + CW'(1);
                        end
                    end
                end
                FULL:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_writeback_unit.sv
// Bench for reg_writeback_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_reg_writeback_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, alu_ready;
    logic [1:0]  alu_dest;
    logic [63:0] alu_data;
    logic        mem_valid, mem_ready;
    logic [1:0]  mem_dest;
    logic [15:0] mem_lane_data;
    logic        regWrEnSc, regWrEnVec;
    logic [1:0]  regToWrite;
    logic [63:0] dataIn;
    logic        wb_pending;
    logic [1:0]  wb_pending_dest;

    int checks = 0;
    int errors = 0;

    // Model: lanes collected so far, their destination, and whether the load is complete.
    logic [15:0] m_lanes[$];
    logic [1:0]  m_dest;
    bit          m_full;
    logic        e_sc, e_vec;
    logic [1:0]  e_dest;
    logic [63:0] e_data;
    bit          dummy;

    always #5 clk = ~clk;

    reg_writeback_unit dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_lane_data(mem_lane_data),
        .regWrEnSc(regWrEnSc), .regWrEnVec(regWrEnVec), .regToWrite(regToWrite), .dataIn(dataIn),
        .wb_pending(wb_pending), .wb_pending_dest(wb_pending_dest)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] load_word();
        logic [63:0] w;
        w = 64'd0;
        if (m_dest[0]) w[15:0] = m_lanes[0];
        else for (int i = 0; i < 4; i++) w[i*16 +: 16] = m_lanes[i];
        return w;
    endfunction

    // Applies the current inputs across one rising edge and checks the result 1 time unit after it.
    task automatic cycle(output bit alu_acc);
        bit mem_acc;
        chk("alu_ready", alu_ready, !m_full);
        chk("mem_ready", mem_ready, !m_full);
        chk("wb_pending", wb_pending, (m_full || m_lanes.size() > 0));
        if (m_full || m_lanes.size() > 0) chk("wb_pending_dest", wb_pending_dest, m_dest);
        alu_acc = alu_valid && !m_full;
        mem_acc = mem_valid && !m_full;
        e_sc = 1'b0;
        e_vec = 1'b0;
        if (m_full) begin
            e_dest = m_dest;
            e_data = load_word();
            e_sc = m_dest[0];
            e_vec = !m_dest[0];
            m_full = 0;
            m_lanes.delete();
        end else if (alu_acc) begin
            e_dest = alu_dest;
            e_sc = alu_dest[0];
            e_vec = !alu_dest[0];
            e_data = alu_dest[0] ? {48'd0, alu_data[15:0]} : alu_data;
        end
        if (mem_acc) begin
            if (m_lanes.size() == 0) m_dest = mem_dest;
            m_lanes.push_back(mem_lane_data);
            if (m_lanes.size() == (m_dest[0] ? 1 : 4)) m_full = 1;
        end
        @(posedge clk);
        #1;
        chk("regWrEnSc", regWrEnSc, e_sc);
        chk("regWrEnVec", regWrEnVec, e_vec);
        chk("regToWrite", regToWrite, e_dest);
        chk("dataIn", dataIn, e_data);
        chk("enables_exclusive", regWrEnSc & regWrEnVec, 1'b0);
    endtask

    task automatic beat(input logic [1:0] d, input logic [15:0] v);
        mem_valid = 1'b1;
        mem_dest = d;
        mem_lane_data = v;
        cycle(dummy);
        mem_valid = 1'b0;
    endtask

    initial begin
        bit acc;
        reset = 1'b0;
        alu_valid = 1'b0; alu_dest = 2'd0; alu_data = 64'd0;
        mem_valid = 1'b0; mem_dest = 2'd0; mem_lane_data = 16'd0;
        m_full = 0; m_dest = 2'd0;
        e_sc = 1'b0; e_vec = 1'b0; e_dest = 2'd0; e_data = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sc", regWrEnSc, 1'b0);
        chk("rst_vec", regWrEnVec, 1'b0);
        chk("rst_dest", regToWrite, 2'd0);
        chk("rst_data", dataIn, 64'd0);
        chk("rst_pending", wb_pending, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // ALU vector then ALU scalar
        alu_valid = 1'b1; alu_dest = 2'b10; alu_data = 64'h0004_0003_0002_0001;
        cycle(acc);
        chk("t1_vec", regWrEnVec, 1'b1);
        chk("t1_data", dataIn, 64'h0004_0003_0002_0001);
        alu_dest = 2'b01; alu_data = 64'hFFFF_FFFF_FFFF_BEEF;
        cycle(acc);
        chk("t2_sc", regWrEnSc, 1'b1);
        chk("t2_data", dataIn, 64'h0000_0000_0000_BEEF);
        alu_valid = 1'b0;
        cycle(acc);
        chk("t2_pulse_end", regWrEnSc, 1'b0);

        // Vector load with a gap after beat 2
        beat(2'b00, 16'h0011);
        chk("t3_pending", wb_pending, 1'b1);
        beat(2'b00, 16'h0022);
        cycle(acc); cycle(acc);
        beat(2'b00, 16'h0033);
        beat(2'b00, 16'h0044);
        chk("t3_full_ready", mem_ready, 1'b0);
        cycle(acc);
        chk("t3_vec", regWrEnVec, 1'b1);
        chk("t3_data", dataIn, 64'h0044_0033_0022_0011);
        chk("t3_pending_clear", wb_pending, 1'b0);

        // Collision: ALU held across the FULL cycle
        for (int i = 0; i < 4; i++) beat(2'b10, 16'(16'h0100 + i));
        alu_valid = 1'b1; alu_dest = 2'b11; alu_data = 64'h0000_0000_0000_CAFE;
        chk("t4_alu_stall", alu_ready, 1'b0);
        cycle(acc);
        chk("t4_load_first", regToWrite, 2'b10);
        cycle(acc);
        chk("t4_alu_second", regWrEnSc, 1'b1);
        alu_valid = 1'b0;
        cycle(acc);

        // Reset mid-burst discards the partial load
        beat(2'b00, 16'hDEAD);
        beat(2'b00, 16'hBEEF);
        #2 reset = 1'b0;
        #1;
        chk("t5_sc", regWrEnSc, 1'b0);
        chk("t5_vec", regWrEnVec, 1'b0);
        chk("t5_data", dataIn, 64'd0);
        chk("t5_pending", wb_pending, 1'b0);
        m_lanes.delete(); m_full = 0;
        e_sc = 1'b0; e_vec = 1'b0; e_dest = 2'd0; e_data = 64'd0;
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) beat(2'b00, 16'(16'h0A00 + i));
        cycle(acc);
        chk("t5_new_data", dataIn, 64'h0A03_0A02_0A01_0A00);

        // Back-to-back scalar loads
        beat(2'b01, 16'h1111);
        chk("t6_ready_low", mem_ready, 1'b0);
        mem_valid = 1'b1; mem_dest = 2'b11; mem_lane_data = 16'h2222;
        cycle(acc);
        chk("t6_first", dataIn, 64'h0000_0000_0000_1111);
        cycle(acc);
        mem_valid = 1'b0;
        chk("t6_ready_low2", mem_ready, 1'b0);
        cycle(acc);
        chk("t6_second_sc", regWrEnSc, 1'b1);
        chk("t6_second", dataIn, 64'h0000_0000_0000_2222);

        // Randomized traffic; ALU source holds its request until accepted
        acc = 1'b1;
        for (int n = 0; n < 500; n++) begin
            if (!alu_valid || acc) begin
                alu_valid = ($urandom_range(0, 99) < 40);
                alu_dest  = 2'($urandom_range(0, 3));
                alu_data  = {$urandom, $urandom};
            end
            mem_valid     = ($urandom_range(0, 99) < 50);
            mem_dest      = 2'($urandom_range(0, 3));
            mem_lane_data = 16'($urandom);
            cycle(acc);
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        repeat (6) cycle(acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
